// File: rtl/m3_sixstep_drive.sv
// m3_sixstep_drive -- six-step commutation generator for one three-phase bridge.
//
// A RUN/IDLE controller counts clocks within each commutation step. At the end
// of a step it advances the step index (forward or reverse), pulses stepPulse,
// and slews the running period toward a target period by at most PER_STEP.
// Each step opens with DEAD_CYC clocks of an all-off bridge. The gate pattern is
// decoded from registered state and then registered once more, so the gates lag
// the internal state by one clock.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   m3start                  pulse: start from IDLE (ignored while running)
//   m3forceStop              immediate stop, overrides m3start
//   m3invRotate              direction level, latched at start
//   m3freqINC / m3freqDEC    shorten / lengthen the target step period
//   aHP,bHP,cHP              high-side gates, active-high
//   aLN,bLN,cLN              low-side gates, active-low
//   busy, dirRev, stepIdx    run flag, latched direction, current step 0..5
//   stepPulse                one clock per commutation (aligned with gate lag)
//   perNow                   running step period
module m3_sixstep_drive #(
  parameter int PER_W    = 16,
  parameter int PER_MAX  = 50000,
  parameter int PER_MIN  = 1000,
  parameter int PER_STEP = 100,
  parameter int DEAD_CYC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m3start,
  input  logic             m3forceStop,
  input  logic             m3invRotate,
  input  logic             m3freqINC,
  input  logic             m3freqDEC,
  output logic             aHP,
  output logic             bHP,
  output logic             cHP,
  output logic             aLN,
  output logic             bLN,
  output logic             cLN,
  output logic             busy,
  output logic             dirRev,
  output logic [2:0]       stepIdx,
  output logic             stepPulse,
  output logic [PER_W-1:0] perNow
);

  localparam int W1 = PER_W + 1;
  localparam logic [PER_W:0]   MAX_X  = W1'(PER_MAX);
  localparam logic [PER_W:0]   MIN_X  = W1'(PER_MIN);
  localparam logic [PER_W:0]   STEP_X = W1'(PER_STEP);
  localparam logic [PER_W-1:0] MAX_N  = PER_W'(PER_MAX);
  localparam logic [PER_W-1:0] STEP_N = PER_W'(PER_STEP);
  localparam logic [PER_W-1:0] DEAD_N = PER_W'(DEAD_CYC);
  // {aHP,bHP,cHP,aLN,bLN,cLN} with every switch open
  localparam logic [5:0]       GATE_OFF = 6'b000_111;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] per_cur;
  logic [PER_W-1:0] per_tgt;
  logic             step_evt_p1;
  logic [5:0]       gate_p0;

  // Saturating target update; one guard bit keeps the add/subtract from wrapping.
  function automatic logic [PER_W-1:0] tgt_next(input logic [PER_W-1:0] tgt,
                                                 input logic inc, input logic dec);
    logic [PER_W:0] t;
    t = {1'b0, tgt};
    if (inc && !dec)
      t = (t < MIN_X + STEP_X) ? MIN_X : t - STEP_X;
    else if (dec && !inc)
      t = (t + STEP_X > MAX_X) ? MAX_X : t + STEP_X;
    return t[PER_W-1:0];
  endfunction

  // Slew the running period toward the target, landing exactly when close.
  function automatic logic [PER_W-1:0] per_slew(input logic [PER_W-1:0] cur,
                                                 input logic [PER_W-1:0] tgt);
    if (cur > tgt)
      return (cur - tgt > STEP_N) ? cur - STEP_N : tgt;
    else
      return (tgt - cur > STEP_N) ? cur + STEP_N : tgt;
  endfunction

  // High-side / low-side phase per step: AB, AC, BC, BA, CA, CB.
  function automatic logic [5:0] step_gates(input logic [2:0] s);
    case (s)
      3'd0:    return 6'b100_101;
      3'd1:    return 6'b100_110;
      3'd2:    return 6'b010_110;
      3'd3:    return 6'b010_011;
      3'd4:    return 6'b001_011;
      3'd5:    return 6'b001_101;
      default: return GATE_OFF;
    endcase
  endfunction

  function automatic logic [2:0] step_next(input logic [2:0] s, input logic rev);
    if (rev)
      return (s == 3'd0) ? 3'd5 : s - 3'd1;
    else
      return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  // Stage p0: gate decode from registered state
  always_comb begin
    gate_p0 = GATE_OFF;
    if (state == RUN && cnt >= DEAD_N)
      gate_p0 = step_gates(stepIdx);
  end

  // Stage p1: control state, counters and registered gate outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stepIdx     <= 3'd0;
      per_cur     <= MAX_N;
      per_tgt     <= MAX_N;
      dirRev      <= 1'b0;
      step_evt_p1 <= 1'b0;
      stepPulse   <= 1'b0;
      {aHP, bHP, cHP, aLN, bLN, cLN} <= GATE_OFF;
    end else begin
      {aHP, bHP, cHP, aLN, bLN, cLN} <= gate_p0;
      stepPulse   <= step_evt_p1;
      step_evt_p1 <= 1'b0;
      per_tgt     <= tgt_next(per_tgt, m3freqINC, m3freqDEC);
      if (m3forceStop) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (m3start) begin
              state   <= RUN;
              cnt     <= '0;
              stepIdx <= 3'd0;
              per_cur <= MAX_N;
              dirRev  <= m3invRotate;
            end
          end
          RUN: begin
            if (cnt == per_cur - PER_W'(1)) begin
              cnt         <= '0;
              stepIdx     <= step_next(stepIdx, dirRev);
              per_cur     <= per_slew(per_cur, per_tgt);
              step_evt_p1 <= 1'b1;
            end else begin
              cnt <= cnt + PER_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy   = (state == RUN);
  assign perNow = per_cur;

endmodule

// File: doc/m3_sixstep_drive.md
Name: m3_sixstep_drive

Overview:
- Parametrised successor to the fixed three-phase motor core: six-step commutation generator for one three-phase bridge.
- Adds configurable step-period width, programmable dead time at every commutation, a speed target with a ramp limiter, direction latch and status outputs.
- Runs in the system clock domain.
- Drives the aHP/aLN…cLN gate pins.
- Takes the m3start/m3forceStop/m3invRotate/m3freqINC/m3freqDEC controls as already-synchronised single-cycle pulses or levels.

Parameters:
- PER_W, 16, width of the step-period counter and registers.
- PER_MAX, 50000, slowest step period in clocks; start and reset value.
- PER_MIN, 1000, fastest step period; must satisfy DEAD_CYC+2 <= PER_MIN <= PER_MAX.
- PER_STEP, 100, change per INC/DEC pulse and maximum change of the running period per commutation.
- DEAD_CYC, 10, clocks with all gates off at the start of every step; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- m3start  in  1  pulse: start from IDLE
- m3forceStop  in  1  level/pulse: immediate stop, highest priority
- m3invRotate  in  1  level: 1 = reverse; sampled only at start
- m3freqINC  in  1  pulse: target period -= PER_STEP
- m3freqDEC  in  1  pulse: target period += PER_STEP
- aHP,bHP,cHP  out  1 each  high-side gate, active-high
- aLN,bLN,cLN  out  1 each  low-side gate, active-low (0 = on)
- busy  out  1  1 while in RUN
- dirRev  out  1  latched direction
- stepIdx  out  3  current step 0..5
- stepPulse  out  1  one clock at each commutation
- perNow  out  PER_W  running step period

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, stepIdx=0, per_cur=per_tgt=PER_MAX.
  - dirRev=0, busy=0, stepPulse=0.
  - All xHP=0, all xLN=1 (bridge off).
- States:
  - IDLE: gates off. m3start and not m3forceStop -> RUN with cnt=0, stepIdx=0, per_cur=PER_MAX, dirRev<=m3invRotate. m3start while in RUN is ignored.
  - RUN:
    - cnt increments each clock.
    - When cnt==per_cur-1: cnt<=0, stepIdx advances (forward 0→1…5→0; reverse 0→5…1→0), stepPulse=1 next cycle, and per_cur moves toward per_tgt by at most PER_STEP (exact match if closer).
  - m3forceStop in any state -> IDLE next clock, gates off on the following clock. It overrides a same-cycle m3start. per_tgt is kept; per_cur is reloaded at the next start.
- Gate pattern, decoded from registered state/step/cnt and then registered (one-clock lag):
  - Bridge is off while cnt<DEAD_CYC.
  - Otherwise, per step (high-side phase on / low-side phase on):
    - 0: A/B
    - 1: A/C
    - 2: B/C
    - 3: B/A
    - 4: C/A
    - 5: C/B
  - The third phase is off.
  - Never both HP=1 and LN=0 on the same phase, in any cycle.
- Target period:
  - INC alone: per_tgt=max(per_tgt-PER_STEP, PER_MIN).
  - DEC alone: per_tgt=min(per_tgt+PER_STEP, PER_MAX).
  - INC and DEC together: no change.
  - Accepted in any state.
  - Arithmetic is done PER_W+1 bits wide before saturation, so there is no wrap.
- perNow=per_cur. stepIdx and dirRev are registered. busy=(state==RUN).
- rst mid-run: next clock all reset values, bridge off.

Test Plan:
- Reset, then PER_MAX=20, DEAD_CYC=4, fwd. Pulse m3start at edge E0:
  - Gates off through E4.
  - At E5: aHP=1, bLN=0, others off.
  - stepPulse at E21.
  - Step 1 pattern (aHP=1, cLN=0) at E25.
- Run 7 commutations with m3invRotate=1 at start → stepIdx sequence 0,5,4,3,2,1,0. Toggling m3invRotate mid-run has no effect.
- PER_MAX=50000, PER_MIN=1000, PER_STEP=100, 600 INC pulses:
  - per_tgt saturates at 1000.
  - perNow decreases 100 per commutation to 1000.
  - Simultaneous INC+DEC leaves per_tgt unchanged.
- m3forceStop asserted mid-step together with m3start:
  - busy=0 next clock.
  - All HP=0 / LN=1 the clock after.
  - Restart begins at per_cur=PER_MAX with the retained per_tgt.
- Assert rst during RUN → all outputs at reset values one clock later.
- Assertion across all runs: no phase ever has HP=1 with LN=0. Every stepIdx change is followed by DEAD_CYC clocks of an all-off bridge.
